ifid_hazard_unit: RTL

- Consumer side of the instruction-fetch interface: latches the fetched instruction and PC into the IF/ID pipeline register.
- Drives the fetch stage's stall (stop) and redirect (jump, jump_addr) inputs.
- Detects load-use hazards against EX and resolves taken branches/jumps from EX by flushing wrong-path instructions.
- Keeps stall and flush performance counters.

---
 rtl/ifid_hazard_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/ifid_hazard_unit.sv
// IF/ID pipeline register with load-use stall detection and EX-resolved redirect/flush.
// Also keeps free-running stall and flush performance counters.
module ifid_hazard_unit #(
    parameter logic [31:0] RESET_PC = 32'h0800_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_inst,
    input  logic [31:0] if_pc,
    output logic        stop,
    output logic        jump,
    output logic [31:0] jump_addr,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_valid,
    output logic        ex_bubble,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned OPW  = 7;

    localparam logic [OPW-1:0] OP_REG    = 7'b0110011;
    localparam logic [OPW-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPW-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPW-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPW-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPW-1:0] OP_JALR   = 7'b1100111;

    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            rd_match;
    logic            load_use;

    assign opcode = id_inst[6:0];
    assign rs1    = id_inst[19:15];
    assign rs2    = id_inst[24:20];

    // Source-register usage by opcode class
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_REG, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                uses_rs1 = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    assign rd_match = (uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd));
    assign load_use = id_valid && ex_is_load && (ex_rd != REGW'(0)) && rd_match;

    // A redirect wins over a stall: the stalled instruction is on the wrong path
    assign jump      = ex_br_taken;
    assign jump_addr = ex_br_target;
    assign stop      = load_use && !ex_br_taken;
    assign ex_bubble = ex_br_taken || load_use;

    // IF/ID register and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_inst   <= NOP_INST;
            id_pc     <= RESET_PC;
            id_valid  <= 1'b0;
            stall_cnt <= XLEN'(0);
            flush_cnt <= XLEN'(0);
        end else if (ex_br_taken) begin
            id_inst   <= NOP_INST;
            id_pc     <= if_pc;
            id_valid  <= 1'b0;
            flush_cnt <= flush_cnt + XLEN'(1);
        end else if (load_use) begin
            stall_cnt <= stall_cnt + XLEN'(1);
        end else begin
            id_inst   <= if_inst;
            id_pc     <= if_pc;
            id_valid  <= 1'b1;
        end
    end

endmodule
